// File: rtl/itlb_micro_pkg.sv
// -----------------------------------------------------------------------------
// itlb_micro_pkg
// Shared CPU-side types for the instruction micro-TLB:
//   virt_t        - 32-bit virtual address
//   tlb_result_t  - main-TLB lookup result (miss, valid, phys_addr, g, cached)
//   utlb_entry_t  - one micro-TLB entry
//   utlb_state_t  - micro-TLB controller state
// Also holds the default entry count and the unmapped-segment test.
// -----------------------------------------------------------------------------
package itlb_micro_pkg;

    typedef logic [31:0] virt_t;

    typedef struct packed {
        logic        miss;
        logic        valid;
        logic [31:0] phys_addr;
        logic        g;
        logic        cached;
    } tlb_result_t;

    typedef struct packed {
        logic        valid;
        logic [19:0] vpn;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn;
        logic        cached;
    } utlb_entry_t;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } utlb_state_t;

    localparam int UTLB_ENTRIES_DEF = 4;

    // kseg0/kseg1: translated by address arithmetic, never through the TLB
    function automatic logic is_unmapped(input virt_t va);
        return (va[31:30] == 2'b10);
    endfunction

endpackage

// File: rtl/itlb_micro_utlb_match.sv
// -----------------------------------------------------------------------------
// itlb_micro_utlb_match
// Combinational fully-associative compare of all micro-TLB entries.
// Ports:
//   i_entries   - entry array
//   i_vpn       - virtual page number being looked up
//   i_asid      - live ASID
//   o_hit       - at least one entry matches
//   o_hit_idx   - index of the matching entry (lowest index on multi-match)
//   o_hit_entry - contents of the selected entry
// -----------------------------------------------------------------------------
module itlb_micro_utlb_match
    import itlb_micro_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  utlb_entry_t       i_entries [N],
    input  logic [19:0]       i_vpn,
    input  logic [7:0]        i_asid,
    output logic              o_hit,
    output logic [PTR_W-1:0]  o_hit_idx,
    output utlb_entry_t       o_hit_entry
);

    logic [N-1:0] w_match;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_match[i] = i_entries[i].valid
                       & (i_entries[i].vpn == i_vpn)
                       & (i_entries[i].g | (i_entries[i].asid == i_asid));
        end
    end

    // Scan from the top so the lowest matching index is the last to be written.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit     = 1'b1;
                o_hit_idx = PTR_W'(i);
            end
        end
    end

    assign o_hit_entry = i_entries[o_hit_idx];

endmodule

// File: rtl/itlb_micro.sv
// -----------------------------------------------------------------------------
// itlb_micro
// Fully-associative instruction micro-TLB between fetch and the main TLB.
// Hit: 1-cycle response. Micro miss: one REFILL cycle querying the main TLB
// combinationally, then a 2nd-cycle response and round-robin fill.
// Main-TLB misses and invalid pages are reported and never cached.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   asid               - current EntryHi.ASID
//   flush              - invalidate all entries (TLBWI/TLBWR commit)
//   req_valid/vaddr    - fetch request; req_ready high in IDLE
//   resp_valid         - one-cycle response strobe
//   resp_paddr/miss/invalid/uncached - response payload, held between strobes
//   tlb_vaddr          - address to main TLB instruction lookup port
//   tlb_result         - combinational main-TLB result for tlb_vaddr
//   hit_cnt, miss_cnt  - performance counters (UTLB_PERF_CNT_EN only)
//
// Build option: define UTLB_PERF_CNT_EN to add saturating hit/miss counters.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | accepting requests; hits and unmapped answered next cycle
// REFILL | one cycle: main TLB looked up on held vaddr, result registered
// -----------------------------------------------------------------------------
module itlb_micro
    import itlb_micro_pkg::*;
#(
    parameter int UTLB_ENTRIES = UTLB_ENTRIES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  asid,
    input  logic        flush,
    input  logic        req_valid,
    input  virt_t       req_vaddr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_paddr,
    output logic        resp_miss,
    output logic        resp_invalid,
    output logic        resp_uncached,
    output virt_t       tlb_vaddr,
    input  tlb_result_t tlb_result
`ifdef UTLB_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int PTR_W = $clog2(UTLB_ENTRIES);

    utlb_state_t      r_state;
    utlb_state_t      w_state_nxt;
    virt_t            r_vaddr;
    utlb_entry_t      r_entries [UTLB_ENTRIES];
    logic [PTR_W-1:0] r_rr;

    logic        r_resp_valid;
    logic [31:0] r_resp_paddr;
    logic        r_resp_miss;
    logic        r_resp_invalid;
    logic        r_resp_uncached;

    logic             w_accept;
    logic             w_unmapped;
    logic             w_in_refill;
    logic             w_hit;
    logic [PTR_W-1:0] w_hit_idx;
    utlb_entry_t      w_hit_entry;
    logic             w_fill;

    itlb_micro_utlb_match #(
        .N     (UTLB_ENTRIES),
        .PTR_W (PTR_W)
    ) u_match (
        .i_entries   (r_entries),
        .i_vpn       (req_vaddr[31:12]),
        .i_asid      (asid),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx),
        .o_hit_entry (w_hit_entry)
    );

    // Only pfn/cached of the selected entry feed the response; index and tag
    // fields are available for debug but not needed here.
    logic w_unused_match;
    assign w_unused_match = &{1'b0, w_hit_idx, w_hit_entry.valid,
                              w_hit_entry.vpn, w_hit_entry.asid, w_hit_entry.g};

    assign w_unmapped = is_unmapped(req_vaddr);
    assign w_accept   = req_valid & req_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_unmapped && !w_hit) begin
                    w_state_nxt = REFILL;
                end
            end
            REFILL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready   = 1'b0;
        w_in_refill = 1'b0;
        case (r_state)
            IDLE:    req_ready   = 1'b1;
            REFILL:  w_in_refill = 1'b1;
            default: req_ready   = 1'b0;
        endcase
    end

    // A flush in the refill cycle drops the fill but not the response.
    assign w_fill = w_in_refill & ~tlb_result.miss & tlb_result.valid & ~flush;

    // Held address, response registers, entry array and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vaddr         <= '0;
            r_rr            <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_paddr    <= '0;
            r_resp_miss     <= 1'b0;
            r_resp_invalid  <= 1'b0;
            r_resp_uncached <= 1'b0;
            for (int i = 0; i < UTLB_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_resp_valid <= 1'b0;

            if (w_accept) begin
                r_vaddr <= req_vaddr;
                if (w_unmapped) begin
                    r_resp_valid    <= 1'b1;
                    r_resp_paddr    <= {3'b000, req_vaddr[28:0]};
                    r_resp_uncached <= req_vaddr[29];
                    r_resp_miss     <= 1'b0;
                    r_resp_invalid  <= 1'b0;
                end else if (w_hit) begin
                    r_resp_valid    <= 1'b1;
                    r_resp_paddr    <= {w_hit_entry.pfn, req_vaddr[11:0]};
                    r_resp_uncached <= ~w_hit_entry.cached;
                    r_resp_miss     <= 1'b0;
                    r_resp_invalid  <= 1'b0;
                end
            end

            if (w_in_refill) begin
                r_resp_valid <= 1'b1;
                if (tlb_result.miss) begin
                    r_resp_paddr    <= '0;
                    r_resp_miss     <= 1'b1;
                    r_resp_invalid  <= 1'b0;
                    r_resp_uncached <= 1'b0;
                end else if (!tlb_result.valid) begin
                    r_resp_paddr    <= '0;
                    r_resp_miss     <= 1'b0;
                    r_resp_invalid  <= 1'b1;
                    r_resp_uncached <= 1'b0;
                end else begin
                    r_resp_paddr    <= tlb_result.phys_addr;
                    r_resp_miss     <= 1'b0;
                    r_resp_invalid  <= 1'b0;
                    r_resp_uncached <= ~tlb_result.cached;
                end
            end

            if (w_fill) begin
                r_entries[r_rr].valid  <= 1'b1;
                r_entries[r_rr].vpn    <= r_vaddr[31:12];
                r_entries[r_rr].asid   <= asid;
                r_entries[r_rr].g      <= tlb_result.g;
                r_entries[r_rr].pfn    <= tlb_result.phys_addr[31:12];
                r_entries[r_rr].cached <= tlb_result.cached;
                r_rr                   <= r_rr + 1'b1;
            end

            if (flush) begin
                for (int i = 0; i < UTLB_ENTRIES; i++) begin
                    r_entries[i].valid <= 1'b0;
                end
            end
        end
    end

    assign resp_valid    = r_resp_valid;
    assign resp_paddr    = r_resp_paddr;
    assign resp_miss     = r_resp_miss;
    assign resp_invalid  = r_resp_invalid;
    assign resp_uncached = r_resp_uncached;
    assign tlb_vaddr     = r_vaddr;

`ifdef UTLB_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept && !w_unmapped) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_itlb_micro.sv
// -----------------------------------------------------------------------------
// tb_itlb_micro
// Directed bench for itlb_micro (default build, 4 entries). A small main-TLB
// model answers tlb_vaddr combinationally; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_itlb_micro;
    import itlb_micro_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  asid;
    logic        flush;
    logic        req_valid;
    virt_t       req_vaddr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_miss;
    logic        resp_invalid;
    logic        resp_uncached;
    virt_t       tlb_vaddr;
    tlb_result_t tlb_result;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    itlb_micro #(.UTLB_ENTRIES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .asid          (asid),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_vaddr     (req_vaddr),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_paddr    (resp_paddr),
        .resp_miss     (resp_miss),
        .resp_invalid  (resp_invalid),
        .resp_uncached (resp_uncached),
        .tlb_vaddr     (tlb_vaddr),
        .tlb_result    (tlb_result)
    );

    function automatic tlb_result_t mk(input logic [19:0] pfn, input logic g,
                                       input logic cached, input logic valid,
                                       input logic [11:0] off);
        tlb_result_t r;
        r.miss      = 1'b0;
        r.valid     = valid;
        r.phys_addr = {pfn, off};
        r.g         = g;
        r.cached    = cached;
        return r;
    endfunction

    // Main TLB contents:
    //   0x00400 asid 5, g=0 -> 0x01234 cached
    //   0x00500         -> miss
    //   0x00600         -> V=0
    //   0x00700 g=1     -> 0x07777 uncached
    //   0x00800 g=1     -> 0x08888 cached
    //   0x00900 g=1     -> 0x09999 cached
    //   0x01001..0x01005 g=1 -> 0x02001..0x02005 cached
    always_comb begin
        tlb_result      = '0;
        tlb_result.miss = 1'b1;
        if (tlb_vaddr[31:12] == 20'h00400) begin
            if (asid == 8'd5) tlb_result = mk(20'h01234, 1'b0, 1'b1, 1'b1, tlb_vaddr[11:0]);
        end else if (tlb_vaddr[31:12] == 20'h00600) begin
            tlb_result = mk(20'h06666, 1'b1, 1'b1, 1'b0, tlb_vaddr[11:0]);
        end else if (tlb_vaddr[31:12] == 20'h00700) begin
            tlb_result = mk(20'h07777, 1'b1, 1'b0, 1'b1, tlb_vaddr[11:0]);
        end else if (tlb_vaddr[31:12] == 20'h00800) begin
            tlb_result = mk(20'h08888, 1'b1, 1'b1, 1'b1, tlb_vaddr[11:0]);
        end else if (tlb_vaddr[31:12] == 20'h00900) begin
            tlb_result = mk(20'h09999, 1'b1, 1'b1, 1'b1, tlb_vaddr[11:0]);
        end else if (tlb_vaddr[31:16] == 16'h0100 && tlb_vaddr[15:12] >= 4'd1
                     && tlb_vaddr[15:12] <= 4'd5) begin
            tlb_result = mk({16'h0200, tlb_vaddr[15:12]}, 1'b1, 1'b1, 1'b1, tlb_vaddr[11:0]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // fl: 0 = no flush, 1 = flush during REFILL cycle, 2 = flush in accept cycle
    task automatic do_req(input virt_t va, input int fl, output int lat);
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_vaddr = va;
        flush     = (fl == 2);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        lat       = 0;
        for (int c = 1; c <= 6; c++) begin
            if (resp_valid) begin
                lat = c;
                break;
            end
            if (c == 1) begin
                check("ready_refill", 32'(req_ready), 32'd0);
                check("tlb_vaddr", tlb_vaddr, va);
                flush = (fl == 1);
            end
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    task automatic req_chk(input string tag, input virt_t va, input int fl,
                           input int exp_lat, input logic [31:0] exp_pa,
                           input logic exp_unc, input logic exp_miss, input logic exp_inv);
        int lat;
        do_req(va, fl, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_paddr"}, resp_paddr, exp_pa);
        check({tag, "_unc"}, 32'(resp_uncached), 32'(exp_unc));
        check({tag, "_miss"}, 32'(resp_miss), 32'(exp_miss));
        check({tag, "_inv"}, 32'(resp_invalid), 32'(exp_inv));
        @(negedge clk);
        check({tag, "_strobe"}, 32'(resp_valid), 32'd0);
        check({tag, "_hold"}, resp_paddr, exp_pa);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_vaddr = '0;
        asid      = 8'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_paddr", resp_paddr, 32'd0);
        check("rst_miss", 32'(resp_miss), 32'd0);
        check("rst_invalid", 32'(resp_invalid), 32'd0);
        check("rst_uncached", 32'(resp_uncached), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_tlb_vaddr", tlb_vaddr, 32'd0);
        reset = 1'b0;

        req_chk("kseg0", 32'h8000_1234, 0, 1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        req_chk("kseg1", 32'hA000_0010, 0, 1, 32'h0000_0010, 1'b1, 1'b0, 1'b0);

        // five pages into four entries: fifth lands in entry 0 (page 1)
        for (int p = 1; p <= 5; p++) begin
            req_chk("fill5", 32'h0100_0000 | (32'(p) << 12), 0, 2,
                    32'h0200_0000 | (32'(p) << 12), 1'b0, 1'b0, 1'b0);
        end
        req_chk("rr_page2_hit", 32'h0100_2008, 0, 1, 32'h0200_2008, 1'b0, 1'b0, 1'b0);
        req_chk("rr_page1_miss", 32'h0100_1000, 0, 2, 32'h0200_1000, 1'b0, 1'b0, 1'b0);

        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;

        req_chk("map_refill", 32'h0040_0ABC, 0, 2, 32'h0123_4ABC, 1'b0, 1'b0, 1'b0);
        req_chk("map_hit", 32'h0040_0ABC, 0, 1, 32'h0123_4ABC, 1'b0, 1'b0, 1'b0);

        req_chk("tlb_miss", 32'h0050_0000, 0, 2, 32'h0, 1'b0, 1'b1, 1'b0);
        req_chk("tlb_miss_again", 32'h0050_0000, 0, 2, 32'h0, 1'b0, 1'b1, 1'b0);
        req_chk("tlb_inv", 32'h0060_0123, 0, 2, 32'h0, 1'b0, 1'b0, 1'b1);

        asid = 8'd6;
        req_chk("asid_chg", 32'h0040_0ABC, 0, 2, 32'h0, 1'b0, 1'b1, 1'b0);
        req_chk("glob_fill", 32'h0070_0040, 0, 2, 32'h0777_7040, 1'b1, 1'b0, 1'b0);
        asid = 8'd7;
        req_chk("glob_hit", 32'h0070_0040, 0, 1, 32'h0777_7040, 1'b1, 1'b0, 1'b0);
        asid = 8'd5;
        req_chk("asid_back", 32'h0040_0ABC, 0, 1, 32'h0123_4ABC, 1'b0, 1'b0, 1'b0);

        req_chk("flush_refill", 32'h0080_0044, 1, 2, 32'h0888_8044, 1'b0, 1'b0, 1'b0);
        req_chk("post_flush", 32'h0080_0044, 0, 2, 32'h0888_8044, 1'b0, 1'b0, 1'b0);
        req_chk("refilled_hit", 32'h0080_0044, 0, 1, 32'h0888_8044, 1'b0, 1'b0, 1'b0);
        req_chk("flush_idle_hit", 32'h0080_0044, 2, 1, 32'h0888_8044, 1'b0, 1'b0, 1'b0);
        req_chk("after_idle_flush", 32'h0080_0044, 0, 2, 32'h0888_8044, 1'b0, 1'b0, 1'b0);

        // reset while in REFILL: no response afterwards
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = 32'h0090_0010;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_refill_state", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_refill_valid", 32'(resp_valid), 32'd0);
        check("rst_refill_paddr", resp_paddr, 32'd0);
        check("rst_refill_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("rst_refill_valid2", 32'(resp_valid), 32'd0);
        req_chk("after_rst", 32'h0090_0010, 0, 2, 32'h0999_9010, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/itlb_micro.md
Name: itlb_micro

Overview:
- Small fully-associative micro-TLB for the instruction-fetch path. Sits between the fetch stage and the main TLB's instruction lookup port.
- Translates fetch virtual addresses locally in 1 cycle on hit.
- On a micro miss, spends one cycle querying the main TLB combinationally, then refills a local entry round-robin.
- Main-TLB misses and invalid pages are reported to fetch and are never cached.

Parameters:
- UTLB_ENTRIES, 4, number of micro entries; power of two, ≥2.
- PTR_W, $clog2(UTLB_ENTRIES), round-robin pointer width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- asid  in  8  current EntryHi.ASID
- flush  in  1  pulse on any TLBWI/TLBWR commit; invalidates all micro entries
- req_valid  in  1  fetch presents req_vaddr
- req_vaddr  in  32  fetch virtual address (virt_t)
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- resp_valid  out  1  one-cycle response strobe
- resp_paddr  out  32  physical address
- resp_miss  out  1  main-TLB refill exception
- resp_invalid  out  1  page matched but V=0
- resp_uncached  out  1  access is uncached
- tlb_vaddr  out  32  address driven to the main TLB instruction lookup port
- tlb_result  in  tlb_result_t  combinational main-TLB result for tlb_vaddr

Behaviour:
- Reset state:
  - All entry valid bits = 0; rr pointer = 0; state = IDLE.
  - resp_valid = 0; resp_paddr/miss/invalid/uncached = 0.
  - req_ready = 1; tlb_vaddr = 0.
- States:
  - IDLE: req_ready = 1.
  - REFILL: req_ready = 0; lasts exactly 1 cycle, then returns to IDLE.
- Accept in IDLE, with held vaddr = req_vaddr registered at accept:
  - Unmapped (vaddr[31:30] = 2'b10):
    - Next cycle resp_valid = 1, resp_paddr = {3'b000, vaddr[28:0]}, resp_uncached = vaddr[29].
    - No micro lookup, no fill.
  - Mapped hit: an entry matches when `valid & vpn == vaddr[31:12] & (g | entry_asid == asid)`.
    - Next cycle resp_valid = 1, resp_paddr = {pfn, vaddr[11:0]}, resp_uncached = ~cached.
    - Latency 1.
  - Mapped micro miss: go to REFILL; no response this cycle.
- REFILL cycle:
  - tlb_vaddr = held vaddr; tlb_result is sampled at the end of the cycle.
  - Next cycle resp_valid = 1. Total miss latency 2.
  - tlb_result.miss = 1 → resp_miss = 1, resp_paddr = 0, no fill.
  - tlb_result.valid = 0 → resp_invalid = 1, resp_paddr = 0, no fill.
  - Otherwise:
    - Fill entry[rr] with vpn, asid, g, pfn = tlb_result.phys_addr[31:12], cached.
    - rr ← rr + 1, wrapping modulo UTLB_ENTRIES.
    - Respond with the translated paddr.
- Multiple matching entries cannot occur, because fills happen only on micro miss. If they do occur, the lowest index wins.
- flush:
  - All valid bits clear at the next edge; the rr pointer is unchanged.
  - Flush in the same cycle as a fill: flush wins and the fill is dropped. The response is still delivered from tlb_result.
  - Flush in the same cycle as an IDLE lookup: the lookup uses pre-flush contents (the hit is honoured).
- A change of asid needs no flush; entry tags compare against the live asid.
- resp_* outputs other than resp_valid hold their last value when resp_valid = 0.
- Reset in REFILL: abort immediately; no response and no fill.

Optional Feature:
- UTLB_PERF_CNT_EN defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0, saturating at 32'hFFFF_FFFF.
  - hit_cnt increments on a mapped micro hit.
  - miss_cnt increments on entry to REFILL.
  - Unmapped accesses count neither.
- Undefined: ports absent; no counter logic.

Decomposition:
- Shared cpu package holds:
  - utlb_entry_t {valid, vpn[19:0], asid[7:0], g, pfn[19:0], cached}.
  - utlb_state_t {IDLE, REFILL}.
  - The existing virt_t and tlb_result_t, with tlb_result_t extended by g and cached fields.
- One sub-module: utlb_match, combinational compare of all entries producing hit, hit index and the selected entry.

Test Plan:
- Reset, then request 0x8000_1234 → response 1 cycle later, paddr 0x0000_1234, uncached = 0. Request 0xA000_0010 → paddr 0x0000_0010, uncached = 1.
- Main TLB maps VPN 0x00400, ASID 5 → PFN 0x01234. Request 0x0040_0ABC → REFILL, response after 2 cycles, paddr 0x0123_4ABC. Repeating the same request → response after 1 cycle.
- Main TLB miss for 0x0050_0000 → resp_miss = 1, resp_paddr = 0. Repeating the request → REFILL taken again (not cached).
- Five distinct pages with UTLB_ENTRIES = 4 → the fifth overwrites entry 0. Re-request of page 1 → miss; re-request of page 2 → hit.
- Entry with g = 0, asid 5 cached, then asid → 6 → same request misses. An entry with g = 1 still hits.
- flush asserted in the REFILL cycle → response delivered with the correct paddr, but the next identical request misses.
